// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART constants and FSM state encoding (rx and tx)      |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned DEFAULT_DIVISOR = 868;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_cnt : loadable down-counter that parks at zero, with zero flag |
// | Rev 1.0       : initial release                                          |
// +--------------------------------------------------------------------------+
module uart_baud_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : 8-bit UART receiver, mid-bit sampling, valid/ready output      |
// |           Define UART_RX_PARITY_EN for an 11-bit frame with even parity. |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [15:0] c_half_load = 16'(DIVISOR / 2 - 1);
  localparam logic [15:0] c_full_load = 16'(DIVISOR - 1);
  localparam logic [2:0]  c_last_bit  = 3'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic                 rx_s;
  uart_state_t          state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 cnt_load;
  logic [15:0]          cnt_load_val;
  logic                 cnt_zero;
  logic                 stop_evt, load_evt;
`ifdef UART_RX_PARITY_EN
  logic                 perr_pend_q, perr_pend_d;
  logic                 perr_q, perr_d;
`endif

  // Previous synchronized level gives the falling-edge detector; a held-low
  // line (break) therefore cannot retrigger until it has gone high again.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s = sync2_q;

  uart_baud_cnt #(
    .WIDTH(16)
  ) u_baud_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;
    cnt_load     = 1'b0;
    cnt_load_val = c_full_load;
    stop_evt     = 1'b0;
    load_evt     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_pend_d  = perr_pend_q;
    perr_d       = perr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d      = ST_START;
          cnt_load     = 1'b1;
          cnt_load_val = c_half_load;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_load  = 1'b1;
            bit_cnt_d = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_load = 1'b1;
          if (bit_cnt_q == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_zero) begin
          perr_pend_d = rx_s ^ even_parity(shift_q);
          cnt_load    = 1'b1;
          state_d     = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_zero) begin
          stop_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving while the held one is still unconsumed is dropped.
    load_evt = stop_evt && (!valid_q || rx_ready);
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (load_evt) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_pend_q;
`endif
    end
    if (stop_evt && valid_q && !rx_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx at DIVISOR=16               |
// | Rev 1.0    : initial release (honours UART_RX_PARITY_EN)                 |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int unsigned D = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_ON     = 1'b1;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam bit          PAR_ON     = 1'b0;
  localparam int unsigned FRAME_BITS = 10;
`endif
  // 2 synchronizer flops + 1 edge-detect register, half a bit to the start
  // mid-point, whole bits to the stop mid-point, then rx_valid the next clock.
  localparam int unsigned LATENCY = 3 + D / 2 + (FRAME_BITS - 1) * D;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       par;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe_par;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   start_cyc  = 0;
  int   last_rise  = 0;
  int   last_width = 0;
  int   run_len    = 0;
  logic valid_prev = 1'b0;
  rec_t got[$];

  uart_rx #(
    .DIVISOR(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer-side monitor: records accepted bytes and rx_valid pulse shape.
  always @(negedge clk) begin
    if (rx_valid && !valid_prev) last_rise = cyc;
    if (rx_valid) begin
      run_len++;
    end else if (run_len > 0) begin
      last_width = run_len;
      run_len    = 0;
    end
    if (rx_valid && rx_ready) got.push_back('{rx_data, frame_err, parity_err});
    valid_prev = rx_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick(D);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_ON) drive_bit(par);
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic expect_byte(input string name, input logic [7:0] ed, input logic efe,
                             input logic epe);
    rec_t r;
    int   k = 0;
    while (got.size() == 0 && k < 4 * D) begin
      tick(1);
      k++;
    end
    chk({name, "_avail"}, 32'(got.size() != 0), 32'd1);
    if (got.size() != 0) begin
      r = got.pop_front();
      chk({name, "_data"}, 32'(r.d), 32'(ed));
      chk({name, "_ferr"}, 32'(r.fe), 32'(efe));
      chk({name, "_perr"}, 32'(r.pe), 32'(epe));
    end
  endtask

  localparam int NV = 7;
  vec_t tbl[NV];

  initial begin
    logic [7:0] rd;
    logic       rstop, rpar, epe;

    tbl[0] = '{d:8'hA5, stop:1'b1, par:1'b0, exp_d:8'hA5, exp_fe:1'b0, exp_pe_par:1'b0};
    tbl[1] = '{d:8'h81, stop:1'b0, par:1'b0, exp_d:8'h81, exp_fe:1'b1, exp_pe_par:1'b0};
    tbl[2] = '{d:8'h00, stop:1'b1, par:1'b0, exp_d:8'h00, exp_fe:1'b0, exp_pe_par:1'b0};
    tbl[3] = '{d:8'hFF, stop:1'b1, par:1'b0, exp_d:8'hFF, exp_fe:1'b0, exp_pe_par:1'b0};
    tbl[4] = '{d:8'h3C, stop:1'b0, par:1'b0, exp_d:8'h3C, exp_fe:1'b1, exp_pe_par:1'b0};
    tbl[5] = '{d:8'h07, stop:1'b1, par:1'b0, exp_d:8'h07, exp_fe:1'b0, exp_pe_par:1'b1};
    tbl[6] = '{d:8'h07, stop:1'b1, par:1'b1, exp_d:8'h07, exp_fe:1'b0, exp_pe_par:1'b0};

    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    tick(5);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick(2 * D);

    // Table: single frames with the consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].par);
      if (i == 0) begin
        chk("latency", 32'(last_rise - start_cyc), 32'(LATENCY));
        tick(2);
        chk("pulse_width", 32'(last_width), 32'd1);
      end
      expect_byte($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_fe,
                  PAR_ON ? tbl[i].exp_pe_par : 1'b0);
      tick(D);
    end
    chk("tbl_ovr", 32'(overrun), 32'd0);

    // Short low glitch on an idle line must not start a byte.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(12 * D);
    chk("glitch_none", 32'(got.size()), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    expect_byte("glitch_next", 8'h3C, 1'b0, 1'b0);
    tick(D);

    // Break: one 0x00 with framing error, then silence until the line recovers.
    rxd = 1'b0;
    tick((FRAME_BITS + 1) * D);
    expect_byte("break", 8'h00, 1'b1, 1'b0);
    tick(4 * D);
    chk("break_hold", 32'(got.size()), 32'd0);
    rxd = 1'b1;
    tick(2 * D);
    send_frame(8'h5A, 1'b1, 1'b0);
    expect_byte("break_next", 8'h5A, 1'b0, 1'b0);
    tick(D);

    // Reset during data bit 4 of 0xFF abandons it; only 0x12 arrives.
    rxd = 1'b0;
    tick(D);
    rxd = 1'b1;
    tick(4 * D + D / 2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2 * D);
    chk("midrst_none", 32'(got.size()), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0);
    expect_byte("midrst_next", 8'h12, 1'b0, 1'b0);
    tick(2 * D);
    chk("midrst_only", 32'(got.size()), 32'd0);

    // Overrun: two back-to-back bytes with the consumer stalled.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h3C);
    chk("ovr_flag", 32'(overrun), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("ovr_valid_drop", 32'(rx_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    tick(3 * D);
    chk("ovr_sticky_late", 32'(overrun), 32'd1);
    expect_byte("ovr_pop", 8'h3C, 1'b0, 1'b0);
    chk("ovr_dropped", 32'(got.size()), 32'd0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    tick(D);

    // Random frames against the frame-level model.
    rx_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rpar  = 1'($urandom_range(0, 1));
      epe   = PAR_ON && ((($countones(rd) + int'(rpar)) % 2) != 0);
      send_frame(rd, rstop, rpar);
      expect_byte($sformatf("rnd%0d", n), rd, ~rstop, epe);
      tick(int'($urandom_range(1, 2 * D)));
    end
    chk("rnd_ovr", 32'(overrun), 32'd0);
    chk("rnd_extra", 32'(got.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL: param DIVISOR, 868, clk cycles per bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL: port clk  input  1  sole clock, rising edge.
REQ-003 SHALL: port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL: port rxd  input  1  asynchronous serial line, idle high (peer of uart_txd).
REQ-005 SHALL: port rx_data  output  8  received byte, LSB first on the line.
REQ-006 SHALL: port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL: port rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
REQ-008 SHALL: port frame_err  output  1  stop bit sampled low for the held byte.
REQ-009 SHALL: port parity_err  output  1  parity mismatch for the held byte (0 when parity compiled out).
REQ-010 SHALL: port overrun  output  1  sticky; a byte was dropped because rx_valid was still high.

Function
REQ-011 SHALL: pass rxd through a 2-flop synchronizer, init 1; all logic uses the synchronized value.
REQ-012 SHALL: FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL: IDLE -> START on a synchronized falling edge; bit counter loaded with DIVISOR/2 - 1.
REQ-014 SHALL: in START, at counter zero, resample: if high return to IDLE (glitch), else reload DIVISOR-1 and go to DATA.
REQ-015 SHALL: in DATA, sample one bit per DIVISOR cycles into a shift register LSB first; after bit 7 go to PARITY (macro on) or STOP.
REQ-016 SHALL: in PARITY, sample one bit and compare against even parity of the 8 data bits.
REQ-017 SHALL: in STOP, sample the stop bit; frame_err_next = ~sample; return to IDLE in the same cycle.
REQ-018 SHALL: on stop-bit sample, if rx_valid==0 or (rx_valid && rx_ready) the cycle is a load: rx_data, frame_err, parity_err update and rx_valid=1 next cycle.
REQ-019 SHALL: on stop-bit sample with rx_valid==1 and rx_ready==0, discard the new byte, keep held outputs, set overrun.
REQ-020 SHALL: clear rx_valid on the cycle after rx_valid && rx_ready unless a load coincides (REQ-018 wins).
REQ-021 SHALL: clear overrun only on reset.
REQ-022 SHALL: byte latency = 1 clk from stop-bit mid-sample to rx_valid high.
REQ-023 SHALL: rxd held low (break) yields a byte 0x00 with frame_err=1, then FSM waits in IDLE until rxd returns high before detecting a new falling edge.

Reset
REQ-024 SHALL: reset forces IDLE, synchronizer flops 1, rx_data 0x00, rx_valid 0, frame_err 0, parity_err 0, overrun 0, counters 0.
REQ-025 SHALL: reset mid-frame abandons the frame; no partial byte is ever presented.

Configuration
REQ-026 SHALL: macro UART_RX_PARITY_EN defined -> 11-bit frame with even parity bit, PARITY state present, parity_err driven.
REQ-027 SHALL: UART_RX_PARITY_EN undefined -> 10-bit 8N1 frame, PARITY state absent, parity_err tied 0.

Structure
REQ-028 SHALL: shared package uart_pkg holds the FSM state typedef, DATA_BITS=8, and the default DIVISOR constant, also used by the transmitter.
REQ-029 SHALL: one sub-module, uart_baud_cnt (loadable down-counter with zero flag); synchronizer stays inline.

Verification (DIVISOR=16)
REQ-030 SHALL: send 0xA5 8N1, rx_ready=1 -> rx_data=0xA5, rx_valid one-cycle pulse, frame_err=0, latency per REQ-022.
REQ-031 SHALL: 0x3C then 0x5A back-to-back, rx_ready=0 -> rx_data stays 0x3C, overrun=1; after handshake rx_valid drops and overrun stays 1.
REQ-032 SHALL: 0x81 with stop bit driven low -> rx_data=0x81, frame_err=1.
REQ-033 SHALL: 4-cycle low glitch on idle line -> no rx_valid, FSM back in IDLE.
REQ-034 SHALL: reset asserted at DATA bit 4 of 0xFF, then full 0x12 frame -> only 0x12 delivered.
REQ-035 SHALL: with UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
